// File: rtl/muldiv_sequencer.sv
// Front-end sequencer for the 33-bit shift-add multiply/divide core (RISC-V M-extension).
// Optional result cache for repeat operand pairs: define MULDIV_RESULT_CACHE_EN.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            core_run,
    output logic            core_div,
    output logic [XLEN:0]   core_opA,
    output logic [XLEN:0]   core_opB,
    input  logic [XLEN:0]   core_Aval,
    input  logic [XLEN:0]   core_Bval,
    input  logic            core_ready,
    output logic [2:0]      dbg_state
);

    // Both ports transfer on a rising edge where valid and ready are high together;
    // valid never waits on ready, and the response payload is held until it is taken.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        ARM    = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    state_t          state_q;
    logic            req_ready_q;
    logic            resp_valid_q;
    logic [XLEN-1:0] resp_result_q;
    logic            core_run_q;
    logic            core_div_q;
    logic [XLEN:0]   core_opA_q;
    logic [XLEN:0]   core_opB_q;
    logic [2:0]      op_q;
    logic            neg_q;

    logic            is_div_d;
    logic            is_rem_d;
    logic            sgn_div_d;
    logic [XLEN-1:0] abs1_d;
    logic [XLEN-1:0] abs2_d;
    logic [XLEN:0]   opA_d;
    logic [XLEN:0]   opB_d;
    logic            neg_d;
    logic            div0_d;
    logic            ovf_d;
    logic            special_d;
    logic [XLEN-1:0] spec_res_d;
    logic            hit_d;
    logic [XLEN-1:0] hit_res_d;
    logic [XLEN-1:0] core_hi_d;
    logic [XLEN-1:0] core_lo_d;
    logic [XLEN-1:0] core_res_d;
    logic            unused_bits;

`ifdef MULDIV_RESULT_CACHE_EN
    logic            cache_valid_q;
    logic            cache_div_q;
    logic [2:0]      cache_f3_q;
    logic [XLEN-1:0] cache_rs1_q;
    logic [XLEN-1:0] cache_rs2_q;
    logic [XLEN-1:0] cache_hi_q;
    logic [XLEN-1:0] cache_lo_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
`endif

    // hi is the product high word or the remainder; lo is the product low word or the quotient.
    function automatic logic [XLEN-1:0] select_result(input logic [2:0] f3, input logic neg,
                                                     input logic [XLEN-1:0] hi,
                                                     input logic [XLEN-1:0] lo);
        logic [XLEN-1:0] r;
        if (f3[2]) begin
            r = f3[1] ? hi : lo;
            if (neg) r = -r;
        end else begin
            r = (f3[1:0] == 2'd0) ? lo : hi;
        end
        return r;
    endfunction

    always_comb begin
        is_div_d  = req_funct3[2];
        is_rem_d  = req_funct3[1];
        sgn_div_d = req_funct3[2] & ~req_funct3[0];
        abs1_d    = req_rs1[XLEN-1] ? -req_rs1 : req_rs1;
        abs2_d    = req_rs2[XLEN-1] ? -req_rs2 : req_rs2;
        opA_d     = {req_rs1[XLEN-1], req_rs1};
        opB_d     = {req_rs2[XLEN-1], req_rs2};
        case (req_funct3)
            3'd2: opB_d = {1'b0, req_rs2};
            3'd3, 3'd5, 3'd7: begin
                opA_d = {1'b0, req_rs1};
                opB_d = {1'b0, req_rs2};
            end
            3'd4, 3'd6: begin
                opA_d = {1'b0, abs1_d};
                opB_d = {1'b0, abs2_d};
            end
            default: ;
        endcase
        neg_d      = sgn_div_d & (is_rem_d ? req_rs1[XLEN-1] : (req_rs1[XLEN-1] ^ req_rs2[XLEN-1]));
        div0_d     = is_div_d & (req_rs2 == '0);
        ovf_d      = sgn_div_d & (req_rs1 == MIN_NEG) & (req_rs2 == ALL_ONES);
        special_d  = div0_d | ovf_d;
        spec_res_d = div0_d ? (is_rem_d ? req_rs1 : ALL_ONES) : (is_rem_d ? '0 : MIN_NEG);

        // The 64-bit product sits at {Aval[30:0], Bval[32:0]}.
        core_hi_d  = op_q[2] ? core_Aval[XLEN-1:0] : {core_Aval[XLEN-2:0], core_Bval[XLEN]};
        core_lo_d  = core_Bval[XLEN-1:0];
        core_res_d = select_result(op_q, neg_q, core_hi_d, core_lo_d);

`ifdef MULDIV_RESULT_CACHE_EN
        hit_d = cache_valid_q && (cache_div_q == is_div_d) &&
                (req_rs1 == cache_rs1_q) && (req_rs2 == cache_rs2_q) &&
                (is_div_d ? (cache_f3_q[0] == req_funct3[0])
                          : ((req_funct3 == 3'd0) || (cache_f3_q == req_funct3)));
        hit_res_d = select_result(req_funct3, neg_d, cache_hi_q, cache_lo_q);
`else
        hit_d     = 1'b0;
        hit_res_d = '0;
`endif
    end

    assign unused_bits = core_Aval[XLEN];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
            core_run_q    <= 1'b0;
            core_div_q    <= 1'b0;
            core_opA_q    <= '0;
            core_opB_q    <= '0;
            op_q          <= 3'd0;
            neg_q         <= 1'b0;
`ifdef MULDIV_RESULT_CACHE_EN
            cache_valid_q <= 1'b0;
            cache_div_q   <= 1'b0;
            cache_f3_q    <= 3'd0;
            cache_rs1_q   <= '0;
            cache_rs2_q   <= '0;
            cache_hi_q    <= '0;
            cache_lo_q    <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
`endif
        end else begin
            core_run_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q        <= req_funct3;
                        neg_q       <= neg_d;
                        req_ready_q <= 1'b0;
                        if (special_d) begin
                            resp_valid_q  <= 1'b1;
                            resp_result_q <= spec_res_d;
                            state_q       <= RESP;
`ifdef MULDIV_RESULT_CACHE_EN
                            cache_valid_q <= 1'b0;
`endif
                        end else if (hit_d) begin
                            resp_valid_q  <= 1'b1;
                            resp_result_q <= hit_res_d;
                            state_q       <= RESP;
                        end else begin
                            core_run_q <= 1'b1;
                            core_div_q <= is_div_d;
                            core_opA_q <= opA_d;
                            core_opB_q <= opB_d;
                            state_q    <= LAUNCH;
`ifdef MULDIV_RESULT_CACHE_EN
                            rs1_q      <= req_rs1;
                            rs2_q      <= req_rs2;
`endif
                        end
                    end
                end
                LAUNCH: state_q <= ARM;
                // The core is still lowering ready here, so it is not looked at.
                ARM: state_q <= WAIT;
                WAIT: begin
                    if (core_ready) begin
                        resp_valid_q  <= 1'b1;
                        resp_result_q <= core_res_d;
                        state_q       <= RESP;
`ifdef MULDIV_RESULT_CACHE_EN
                        cache_valid_q <= 1'b1;
                        cache_div_q   <= op_q[2];
                        cache_f3_q    <= op_q;
                        cache_rs1_q   <= rs1_q;
                        cache_rs2_q   <= rs2_q;
                        cache_hi_q    <= core_hi_d;
                        cache_lo_q    <= core_lo_d;
`endif
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign core_run    = core_run_q;
    assign core_div    = core_div_q;
    assign core_opA    = core_opA_q;
    assign core_opB    = core_opB_q;
    assign dbg_state   = state_q;

endmodule
